// File: rtl/cmd_parser.sv
// Byte-stream command parser: "!<letter>[1-9]\r" frames from a UART receiver.
// Emits registered command pulses, error pulses and a saturating error count.
module cmd_parser #(
    parameter int TIMEOUT_CYCLES = 27_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_byte,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic [3:0] cmd_amount,
    output logic       err,
    output logic [7:0] err_count,
    output logic       busy
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CH_BANG = 8'h21;
    localparam logic [7:0] CH_CR   = 8'h0D;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_ARG,
        S_END
    } state_t;

    state_t        state, state_n;
    logic [2:0]    code_r, code_n;
    logic [3:0]    amt_r, amt_n;
    logic [CW-1:0] cnt;
    logic          prev_zero;

    logic          new_byte;
    logic [7:0]    letter;
    logic [2:0]    code_dec;
    logic          is_digit;
    logic          emit;
    logic [3:0]    emit_amt;
    logic          error;

    assign new_byte = prev_zero && (rx_byte != 8'h00);
    assign letter   = rx_byte & 8'hDF;
    assign is_digit = (rx_byte >= 8'h31) && (rx_byte <= 8'h39);
    assign busy     = (state != S_IDLE);

    // Bit 5 is masked so upper and lower case letters share one table.
    always_comb begin
        code_dec = 3'd0;
        case (letter)
            8'h46:   code_dec = 3'd1;
            8'h50:   code_dec = 3'd2;
            8'h43:   code_dec = 3'd3;
            8'h53:   code_dec = 3'd4;
            8'h57:   code_dec = 3'd5;
            8'h4D:   code_dec = 3'd6;
            8'h54:   code_dec = 3'd7;
            default: code_dec = 3'd0;
        endcase
    end

    always_comb begin
        state_n  = state;
        code_n   = code_r;
        amt_n    = amt_r;
        emit     = 1'b0;
        emit_amt = 4'd0;
        error    = 1'b0;
        if (new_byte) begin
            case (state)
                S_IDLE: begin
                    if (rx_byte == CH_BANG) state_n = S_CMD;
                end
                S_CMD: begin
                    if (code_dec != 3'd0) begin
                        code_n  = code_dec;
                        state_n = S_ARG;
                    end else if (rx_byte != CH_BANG) begin
                        error   = 1'b1;
                        state_n = S_IDLE;
                    end
                end
                S_ARG: begin
                    if (is_digit) begin
                        amt_n   = rx_byte[3:0];
                        state_n = S_END;
                    end else if (rx_byte == CH_CR) begin
                        emit     = 1'b1;
                        emit_amt = 4'd1;
                        state_n  = S_IDLE;
                    end else begin
                        error   = 1'b1;
                        state_n = (rx_byte == CH_BANG) ? S_CMD : S_IDLE;
                    end
                end
                S_END: begin
                    if (rx_byte == CH_CR) begin
                        emit     = 1'b1;
                        emit_amt = amt_r;
                        state_n  = S_IDLE;
                    end else begin
                        error   = 1'b1;
                        state_n = (rx_byte == CH_BANG) ? S_CMD : S_IDLE;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end else if (state != S_IDLE && cnt == TO_LAST) begin
            // A byte landing on the timeout cycle takes the branch above.
            error   = 1'b1;
            state_n = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            code_r     <= 3'd0;
            amt_r      <= 4'd0;
            cnt        <= '0;
            prev_zero  <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_code   <= 3'd0;
            cmd_amount <= 4'd0;
            err        <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            state     <= state_n;
            code_r    <= code_n;
            amt_r     <= amt_n;
            prev_zero <= (rx_byte == 8'h00);
            if (new_byte || state_n == S_IDLE)
                cnt <= '0;
            else if (state != S_IDLE)
                cnt <= cnt + 1'b1;
            cmd_valid  <= emit;
            cmd_code   <= emit ? code_r : 3'd0;
            cmd_amount <= emit ? emit_amt : 4'd0;
            err        <= error;
            if (error && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_cmd_parser.sv
// Directed testbench for cmd_parser with a short timeout.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_cmd_parser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_byte;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic [3:0] cmd_amount;
    logic       err;
    logic [7:0] err_count;
    logic       busy;

    localparam logic [7:0] CR = 8'h0D;

    int errors = 0;
    int checks = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_both = 0;
    logic [2:0] last_code = 3'd0;
    logic [3:0] last_amt = 4'd0;

    always #5 clk = ~clk;

    cmd_parser #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_byte    (rx_byte),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .cmd_amount (cmd_amount),
        .err        (err),
        .err_count  (err_count),
        .busy       (busy)
    );

    always @(negedge clk) begin
        if (cmd_valid) begin
            n_valid++;
            last_code = cmd_code;
            last_amt  = cmd_amount;
        end
        if (err) n_err++;
        if (cmd_valid && err) n_both++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Called on a falling edge; returns on a falling edge.
    task automatic send(input logic [7:0] b, input int hold);
        rx_byte = b;
        repeat (hold) @(negedge clk);
        rx_byte = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_str(input string s, input int hold);
        for (int i = 0; i < s.len(); i++)
            send(s[i], hold);
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        rx_byte = 8'h21;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_valid, err, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got=%b want=000", {cmd_valid, err, busy});
        end
        checks++;
        if ({cmd_code, cmd_amount, err_count} !== 15'd0) begin
            errors++;
            $display("FAIL reset_data code=%0d amt=%0d cnt=%0d want 0",
                     cmd_code, cmd_amount, err_count);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL held_bang_release busy=%b want=0", busy);
        end
        rx_byte = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        send_str("!F3", 5);
        rx_byte = CR;
        @(negedge clk);
        checks++;
        if ({cmd_valid, cmd_code, cmd_amount} !== {1'b1, 3'd1, 4'd3}) begin
            errors++;
            $display("FAIL basic_latency v=%b code=%0d amt=%0d want v=1 code=1 amt=3",
                     cmd_valid, cmd_code, cmd_amount);
        end
        @(negedge clk);
        checks++;
        if ({cmd_valid, cmd_code, cmd_amount} !== 8'd0) begin
            errors++;
            $display("FAIL basic_pulse v=%b code=%0d amt=%0d want all 0",
                     cmd_valid, cmd_code, cmd_amount);
        end
        repeat (3) @(negedge clk);
        rx_byte = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if (n_valid - v0 !== 1 || n_err - e0 !== 0) begin
            errors++;
            $display("FAIL basic_counts valid=%0d err=%0d want 1/0",
                     n_valid - v0, n_err - e0);
        end
    endtask

    task automatic test_hold;
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        send_str("!s", 5);
        send(CR, 1000);
        checks++;
        if (n_valid - v0 !== 1 || n_err - e0 !== 0) begin
            errors++;
            $display("FAIL hold_counts valid=%0d err=%0d want 1/0",
                     n_valid - v0, n_err - e0);
        end
        checks++;
        if (last_code !== 3'd4 || last_amt !== 4'd1) begin
            errors++;
            $display("FAIL hold_cmd code=%0d amt=%0d want 4/1", last_code, last_amt);
        end
    endtask

    task automatic test_errors;
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        send_str("!X\r", 3);
        send_str("!P0\r", 3);
        checks++;
        if (n_err - e0 !== 2 || n_valid - v0 !== 0) begin
            errors++;
            $display("FAIL frame_errs err=%0d valid=%0d want 2/0",
                     n_err - e0, n_valid - v0);
        end
        checks++;
        if (err_count !== 8'd2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_errcount cnt=%0d busy=%b want 2/0", err_count, busy);
        end
    endtask

    task automatic test_paths;
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        send_str("!!T\r", 3);
        checks++;
        if (n_err - e0 !== 0 || n_valid - v0 !== 1 || last_code !== 3'd7
            || last_amt !== 4'd1) begin
            errors++;
            $display("FAIL double_bang err=%0d valid=%0d code=%0d amt=%0d want 0/1/7/1",
                     n_err - e0, n_valid - v0, last_code, last_amt);
        end
        v0 = n_valid;
        e0 = n_err;
        send_str("!W!T\r", 3);
        checks++;
        if (n_err - e0 !== 1 || n_valid - v0 !== 1 || last_code !== 3'd7
            || last_amt !== 4'd1) begin
            errors++;
            $display("FAIL arg_bang err=%0d valid=%0d code=%0d amt=%0d want 1/1/7/1",
                     n_err - e0, n_valid - v0, last_code, last_amt);
        end
        v0 = n_valid;
        e0 = n_err;
        send_str("!C5!m2\r", 3);
        checks++;
        if (n_err - e0 !== 1 || n_valid - v0 !== 1 || last_code !== 3'd6
            || last_amt !== 4'd2) begin
            errors++;
            $display("FAIL end_bang err=%0d valid=%0d code=%0d amt=%0d want 1/1/6/2",
                     n_err - e0, n_valid - v0, last_code, last_amt);
        end
        v0 = n_valid;
        send_str("!w9\r", 3);
        checks++;
        if (n_valid - v0 !== 1 || last_code !== 3'd5 || last_amt !== 4'd9) begin
            errors++;
            $display("FAIL digit_nine valid=%0d code=%0d amt=%0d want 1/5/9",
                     n_valid - v0, last_code, last_amt);
        end
        v0 = n_valid;
        e0 = n_err;
        send_str("!f9x", 3);
        checks++;
        if (n_err - e0 !== 1 || n_valid - v0 !== 0 || err_count !== 8'd5) begin
            errors++;
            $display("FAIL end_junk err=%0d valid=%0d cnt=%0d want 1/0/5",
                     n_err - e0, n_valid - v0, err_count);
        end
    endtask

    task automatic test_timeout;
        int early;
        send("!", 3);
        rx_byte = "M";
        @(negedge clk);
        rx_byte = 8'h00;
        early = 0;
        repeat (15) begin
            @(negedge clk);
            if (err) early++;
        end
        checks++;
        if (early !== 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early early_errs=%0d busy=%b want 0/1", early, busy);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || err_count !== 8'd6) begin
            errors++;
            $display("FAIL timeout_fire err=%b busy=%b cnt=%0d want 1/0/6",
                     err, busy, err_count);
        end
        repeat (2) @(negedge clk);
        send("!", 3);
        rx_byte = "M";
        @(negedge clk);
        rx_byte = 8'h00;
        early = 0;
        repeat (14) begin
            @(negedge clk);
            if (err) early++;
        end
        rx_byte = CR;
        @(negedge clk);
        checks++;
        if (early !== 0 || err !== 1'b0 || cmd_valid !== 1'b1 || cmd_code !== 3'd6) begin
            errors++;
            $display("FAIL timeout_race early=%0d err=%b v=%b code=%0d want 0/0/1/6",
                     early, err, cmd_valid, cmd_code);
        end
        rx_byte = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_saturate;
        repeat (300) send_str("!X", 1);
        checks++;
        if (err_count !== 8'hFF) begin
            errors++;
            $display("FAIL err_saturate cnt=%0d want 255", err_count);
        end
    endtask

    task automatic test_midreset;
        int v0, e0;
        send_str("!F3", 3);
        v0 = n_valid;
        e0 = n_err;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL midreset_state busy=%b cnt=%0d want 0/0", busy, err_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send(CR, 3);
        checks++;
        if (n_valid - v0 !== 0 || n_err - e0 !== 0) begin
            errors++;
            $display("FAIL midreset_discard valid=%0d err=%0d want 0/0",
                     n_valid - v0, n_err - e0);
        end
        checks++;
        if (n_both !== 0) begin
            errors++;
            $display("FAIL valid_and_err overlaps=%0d want 0", n_both);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_byte = 8'h00;
        @(negedge clk);
        test_reset();
        test_basic();
        test_hold();
        test_errors();
        test_paths();
        test_timeout();
        test_saturate();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
